uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Oversampling UART receiver. It recovers frames from the serial `rx` line and presents each one as a data word plus error flags through a valid/ready handshake.
- It sits directly downstream of the UART line.
- It is the RTL consumer of the shared UART package types: baud/oversampling, stop bits, data width and parity.
- It feeds the monitor/scoreboard path as a parallel word stream.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame; the output word width.
- DIV_WIDTH, 16, width of the baud-tick divisor input.
- SYNC_STAGES, 2, flops in the `rx` metastability synchronizer.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high.
- cfgDivisor  input  DIV_WIDTH  clocks per oversample tick; value 0 is treated as 1.
- cfgOverSampling  input  5  oversample ticks per bit; legal values are 13 and 16.
- cfgDataBits  input  4  data bits per frame; legal range 5..8.
- cfgParityEn  input  1  1 = a parity bit follows the data.
- cfgParityOdd  input  1  1 = odd parity, 0 = even parity.
- cfgStopBits  input  2  1 or 2 stop bits.
- rxData  output  DATA_WIDTH  received word, LSB = first bit received, unused MSBs zero.
- rxValid  output  1  `rxData` and error flags are valid.
- rxReady  input  1  consumer accepts the word.
- parityError  output  1  parity mismatch on the held word.
- framingError  output  1  a stop bit was sampled low on the held word.
- overrunError  output  1  one-cycle pulse: a completed frame was dropped.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset values: `rxData`=0, `rxValid`=0, all error outputs 0, `busy`=0, FSM=IDLE, synchronizer flops=1, counters=0.
- Synchronizer: `rx` passes through SYNC_STAGES flops. The FSM uses the synchronized value `rxS`.
- Tick generator: a counter runs from 0 to max(cfgDivisor,1)-1 and emits a one-cycle `tick` at the terminal count.
  - It restarts from 0 on a start-edge detect.
- Config latching: all cfg* inputs are latched on leaving IDLE. Changes mid-frame have no effect until the next frame.
- IDLE:
  - A falling `rxS` (previous 1, now 0) → START; clear the sample counter.
- START:
  - After floor(OS/2) ticks, sample `rxS`.
  - If 0 → DATA, with the bit counter and sample counter cleared.
  - If 1 → IDLE (glitch rejected; no output, no error).
- DATA:
  - Every OS ticks, sample `rxS` into bit index `bitCnt`, LSB first.
  - After cfgDataBits samples → PARITY if `cfgParityEn`, else → STOP.
- PARITY:
  - After OS ticks, sample the parity bit.
  - Expected value = XOR of the data bits, XOR `cfgParityOdd`.
  - Record a mismatch.
- STOP:
  - Sample after OS ticks for each of `cfgStopBits` stop bits.
  - Any stop bit sampled 0 sets the frame's framing flag.
  - On the last stop sample → COMMIT in the same cycle, then IDLE on the next cycle.
- The FSM does not wait for the full stop period: a new start edge is accepted from the cycle after commit.
- Commit rules:
  - If `rxValid`=0, or `rxReady`=1 in the commit cycle: load `rxData` (bits ≥ cfgDataBits zeroed), `parityError`, `framingError`; `rxValid` goes to 1 next cycle.
  - Else the frame is dropped: `overrunError` pulses 1 for exactly one cycle and the held word is unchanged.
- Handshake:
  - `rxValid` stays high until a cycle with `rxValid`&&`rxReady`.
  - `rxData` and the error flags are stable while `rxValid`=1.
  - The error flags clear together with `rxValid`.
- Latency: `rxValid` rises 1 clk after the final stop-bit sample tick.
- Illegal config:
  - cfgDataBits>DATA_WIDTH or <5 is clamped to 8 or 5 respectively.
  - cfgStopBits of 0 or 3 is treated as 1 and 2 respectively.
  - cfgOverSampling<4 is treated as 16.
- Reset mid-frame: immediate return to the reset state, and any partial frame is discarded.
- Break condition (line held low): produces a frame of zeros with `framingError`=1. The FSM then stays in IDLE until a rising edge followed by a fresh falling edge.

Decomposition:
- Shared UART package additions:
  - `UART_DIV_WIDTH` = 16.
  - Receiver state enum `UartRxState` {IDLE, START, DATA, PARITY, STOP}.
  - Frame-status packed struct {parityError, framingError}.
  - The existing baud, oversampling and stop-bit enums remain the config vocabulary.
  - Fix the package data-width enum: SIX_BIT=6, and widen the enum to 4 bits so FIVE_BIT..EIGHT_BIT are representable, so it maps directly onto `cfgDataBits`.
- Sub-module `uart_baud_tick_gen`: divisor counter with restart, emitting `tick`. It is reusable by the future transmitter.

Test Plan:
- Common config: cfgDivisor=4, OS=16 (64 clk/bit), 8 data bits, no parity, 1 stop bit.
- Basic frame: drive byte 0xA5 with the common config → `rxValid` rises 1 clk after the stop-bit sample with `rxData`=0xA5; `rxReady`=1 clears `rxValid` next cycle.
- Parity: 7 data bits, odd parity, send 0x55 with parity bit 1 → `parityError`=0; resend with parity bit 0 → `parityError`=1 with `rxData`=0x55.
- Framing/break: 8N2, send 0x3C with the second stop bit 0 → `rxData`=0x3C, `framingError`=1; hold `rx`=0 for 20 bit-times → one frame 0x00 with `framingError`, then no further frames until `rx` returns high.
- Overrun: `rxReady`=0, send 0x11 then 0x22 → `rxData` stays 0x11, `overrunError` pulses exactly 1 clk at the second commit; after `rxReady`, `rxValid`=0.
- Glitch/reset: low pulse of 5 clk (< 8 ticks) → no frame, `busy` returns to 0; assert `reset` during bit 3 of a frame → all outputs at reset values next cycle, and a following clean 0x81 is received correctly.
- Oversampling 13: OS=13, cfgDivisor=3, 5 data bits, even parity, send 0x1F with parity bit 1 → `rxData`=0x1F, no errors.

Source files
------------

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART types: config vocabulary, receiver state and per-frame status,
// plus helpers that map illegal config values onto legal ones.
package uart_rx_deserializer_pkg;

    localparam int unsigned UART_DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        BAUD_9600,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200
    } UartBaud;

    typedef enum logic [4:0] {
        OS_13 = 5'd13,
        OS_16 = 5'd16
    } UartOverSampling;

    typedef enum logic [1:0] {
        STOP_1 = 2'd1,
        STOP_2 = 2'd2
    } UartStopBits;

    // 4 bits wide so the values line up directly with cfgDataBits.
    typedef enum logic [3:0] {
        FIVE_BIT  = 4'd5,
        SIX_BIT   = 4'd6,
        SEVEN_BIT = 4'd7,
        EIGHT_BIT = 4'd8
    } UartDataBits;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UartRxState;

    typedef struct packed {
        logic parityError;
        logic framingError;
    } UartFrameStatus;

    function automatic logic [4:0] norm_oversampling(input logic [4:0] os);
        return (os < 5'd4) ? OS_16 : os;
    endfunction

    function automatic logic [1:0] norm_stop_bits(input logic [1:0] sb);
        case (sb)
            2'd0, 2'd1: return STOP_1;
            default:    return STOP_2;
        endcase
    endfunction

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                   input logic [3:0] max_bits);
        if (bits < FIVE_BIT) begin
            return FIVE_BIT;
        end else if (bits > max_bits) begin
            return max_bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Divisor counter emitting a one-cycle tick every max(divisor,1) clocks;
// restart_i realigns the phase so the next tick lands a full period later.
module uart_baud_tick_gen #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] term;
    logic                 at_term;

    always_comb begin
        term    = (divisor_i == '0) ? '0 : divisor_i - DIV_WIDTH'(1);
        // >= so a divisor shrinking below the current count cannot stall.
        at_term = (cnt_q >= term);
        tick_o  = at_term && !restart_i;
        if (restart_i || at_term) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: synchronizes rx, recovers frames and hands each
// word plus its error flags downstream through a valid/ready holding register.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DIV_WIDTH   = UART_DIV_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  cfgDivisor,
    input  logic [4:0]            cfgOverSampling,
    input  logic [3:0]            cfgDataBits,
    input  logic                  cfgParityEn,
    input  logic                  cfgParityOdd,
    input  logic [1:0]            cfgStopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  overrunError,
    output logic                  busy
);

    localparam logic [3:0] MaxDataBits = (DATA_WIDTH > 15) ? 4'd15 : 4'(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    logic                   rx_prev_q, rx_prev_d;
    logic                   fall;

    UartRxState             state_q, state_d;
    logic [4:0]             sample_cnt_q, sample_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    UartFrameStatus         frame_q, frame_d;

    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [4:0]             os_q, os_d;
    logic [3:0]             bits_q, bits_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic [1:0]             stop_q, stop_d;

    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    UartFrameStatus         status_q, status_d;
    logic                   overrun_q, overrun_d;

    logic                   tick;
    logic                   restart;
    logic                   commit;
    logic [4:0]             sample_target;
    logic                   sample_hit;

    assign sync_d    = SYNC_STAGES'({sync_q, rx});
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_prev_d = rx_s;
    assign fall      = rx_prev_q && !rx_s;

    uart_baud_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .divisor_i (div_q),
        .tick_o    (tick)
    );

    // START waits half a bit to land mid start bit; later states wait a full bit.
    always_comb begin
        sample_target = (state_q == START) ? ((os_q >> 1) - 5'd1) : (os_q - 5'd1);
        sample_hit    = tick && (sample_cnt_q == sample_target);
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_d      = frame_q;
        div_d        = div_q;
        os_d         = os_q;
        bits_d       = bits_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        stop_d       = stop_q;
        restart      = 1'b0;
        commit       = 1'b0;

        if (state_q != IDLE && tick) begin
            sample_cnt_d = sample_hit ? 5'd0 : sample_cnt_q + 5'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d      = START;
                    sample_cnt_d = 5'd0;
                    restart      = 1'b1;
                    div_d        = cfgDivisor;
                    os_d         = norm_oversampling(cfgOverSampling);
                    bits_d       = clamp_data_bits(cfgDataBits, MaxDataBits);
                    par_en_d     = cfgParityEn;
                    par_odd_d    = cfgParityOdd;
                    stop_d       = norm_stop_bits(cfgStopBits);
                end
            end
            START: begin
                if (sample_hit) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                        shift_d   = '0;
                        frame_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_hit) begin
                    // Shift register starts cleared, so unused MSBs stay zero.
                    shift_d = shift_q | (DATA_WIDTH'(rx_s) << bit_cnt_q);
                    if (bit_cnt_q == bits_q - 4'd1) begin
                        bit_cnt_d = 4'd0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_hit) begin
                    frame_d.parityError = rx_s ^ (^shift_q) ^ par_odd_q;
                    bit_cnt_d           = 4'd0;
                    state_d             = STOP;
                end
            end
            STOP: begin
                if (sample_hit) begin
                    if (!rx_s) begin
                        frame_d.framingError = 1'b1;
                    end
                    if (bit_cnt_q == {2'b00, stop_q} - 4'd1) begin
                        commit    = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a commit that finds the previous word unconsumed is dropped.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        status_d  = status_q;
        overrun_d = 1'b0;

        if (valid_q && rxReady) begin
            valid_d  = 1'b0;
            status_d = '0;
        end
        if (commit) begin
            if (!valid_q || rxReady) begin
                valid_d  = 1'b1;
                data_d   = shift_q;
                status_d = frame_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            sample_cnt_q <= 5'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            frame_q      <= '0;
            div_q        <= '0;
            os_q         <= 5'd0;
            bits_q       <= 4'd0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop_q       <= 2'd0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            status_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_q      <= frame_d;
            div_q        <= div_d;
            os_q         <= os_d;
            bits_q       <= bits_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop_q       <= stop_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            status_q     <= status_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rxData       = data_q;
    assign rxValid      = valid_q;
    assign parityError  = status_q.parityError;
    assign framingError = status_q.framingError;
    assign overrunError = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives serial frames bit by bit and
// checks the held word, error flags, handshake and commit latency.
module tb_uart_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] cfgDivisor;
    logic [4:0]  cfgOverSampling;
    logic [3:0]  cfgDataBits;
    logic        cfgParityEn;
    logic        cfgParityOdd;
    logic [1:0]  cfgStopBits;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        parityError;
    logic        framingError;
    logic        overrunError;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int ovr_cnt = 0;
    logic prev_v = 1'b0;

    uart_rx_deserializer #(
        .DATA_WIDTH  (8),
        .DIV_WIDTH   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .cfgDivisor      (cfgDivisor),
        .cfgOverSampling (cfgOverSampling),
        .cfgDataBits     (cfgDataBits),
        .cfgParityEn     (cfgParityEn),
        .cfgParityOdd    (cfgParityOdd),
        .cfgStopBits     (cfgStopBits),
        .rxData          (rxData),
        .rxValid         (rxValid),
        .rxReady         (rxReady),
        .parityError     (parityError),
        .framingError    (framingError),
        .overrunError    (overrunError),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Monitor samples 2 time units after each edge; stimulus acts at +1.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (rxValid && !prev_v) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_v = rxValid;
        if (overrunError) ovr_cnt++;
    end

    task automatic set_cfg(input logic [15:0] div, input logic [4:0] os, input logic [3:0] bits,
                           input logic pen, input logic podd, input logic [1:0] stop);
        cfgDivisor      = div;
        cfgOverSampling = os;
        cfgDataBits     = bits;
        cfgParityEn     = pen;
        cfgParityOdd    = podd;
        cfgStopBits     = stop;
    endtask

    task automatic clear_mon();
        rise_cnt = 0;
        ovr_cnt  = 0;
    endtask

    task automatic send_bit(input logic b, input int period);
        rx = b;
        repeat (period) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                              input logic par_bit, input int nstop, input logic stop_last,
                              input int period);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        send_bit(1'b0, period);
        for (int i = 0; i < nbits; i++) send_bit(data[i], period);
        if (par_en) send_bit(par_bit, period);
        for (int i = 0; i < nstop; i++) send_bit((i == nstop - 1) ? stop_last : 1'b1, period);
        rx = 1'b1;
    endtask

    task automatic accept();
        rxReady = 1'b1;
        @(posedge clk);
        #1;
        rxReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rxValid, parityError, framingError, overrunError, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {rxValid, parityError, framingError, overrunError, busy});
        end
        n_cmp++;
        if (rxData !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", rxData);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        set_cfg(16'd4, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        clear_mon();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 64);
        n_cmp++;
        if (rxData !== 8'hA5 || rxValid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_word: got data %h valid %b want a5 1", rxData, rxValid);
        end
        n_cmp++;
        if (rise_cyc - start_cyc !== 611) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want 611", rise_cyc - start_cyc);
        end
        n_cmp++;
        if ({parityError, framingError, overrunError} !== 3'b000 || rise_cnt !== 1) begin
            n_bad++;
            $display("FAIL basic_flags: got %b frames %0d want 000 1",
                     {parityError, framingError, overrunError}, rise_cnt);
        end
        accept();
        n_cmp++;
        if (rxValid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_handshake: got valid %b want 0", rxValid);
        end
    endtask

    task automatic test_parity();
        set_cfg(16'd4, 5'd16, 4'd7, 1'b1, 1'b1, 2'd1);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1, 1'b1, 64);
        n_cmp++;
        if (rxData !== 8'h55 || parityError !== 1'b0 || rxValid !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_good: got data %h perr %b valid %b want 55 0 1",
                     rxData, parityError, rxValid);
        end
        accept();
        send_frame(8'h55, 7, 1'b1, 1'b0, 1, 1'b1, 64);
        n_cmp++;
        if (rxData !== 8'h55 || parityError !== 1'b1 || framingError !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_bad: got data %h perr %b ferr %b want 55 1 0",
                     rxData, parityError, framingError);
        end
        accept();
        n_cmp++;
        if (parityError !== 1'b0 || rxValid !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_clear: got perr %b valid %b want 0 0", parityError, rxValid);
        end
    endtask

    task automatic test_framing_break();
        set_cfg(16'd4, 5'd16, 4'd8, 1'b0, 1'b0, 2'd2);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0, 64);
        n_cmp++;
        if (rxData !== 8'h3C || framingError !== 1'b1 || parityError !== 1'b0) begin
            n_bad++;
            $display("FAIL framing_stop2: got data %h ferr %b perr %b want 3c 1 0",
                     rxData, framingError, parityError);
        end
        accept();
        set_cfg(16'd4, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        clear_mon();
        rx = 1'b0;
        repeat (1280) @(posedge clk);
        #1;
        n_cmp++;
        if (rise_cnt !== 1 || rxData !== 8'h00 || framingError !== 1'b1) begin
            n_bad++;
            $display("FAIL break_frame: got frames %0d data %h ferr %b want 1 00 1",
                     rise_cnt, rxData, framingError);
        end
        n_cmp++;
        if (busy !== 1'b0 || ovr_cnt !== 0) begin
            n_bad++;
            $display("FAIL break_idle: got busy %b overruns %0d want 0 0", busy, ovr_cnt);
        end
        rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (rise_cnt !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL break_release: got frames %0d busy %b want 1 0", rise_cnt, busy);
        end
        accept();
    endtask

    task automatic test_overrun();
        clear_mon();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 64);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 64);
        n_cmp++;
        if (rxData !== 8'h11 || rxValid !== 1'b1 || rise_cnt !== 1) begin
            n_bad++;
            $display("FAIL overrun_hold: got data %h valid %b frames %0d want 11 1 1",
                     rxData, rxValid, rise_cnt);
        end
        n_cmp++;
        if (ovr_cnt !== 1) begin
            n_bad++;
            $display("FAIL overrun_pulse: got %0d cycles want 1", ovr_cnt);
        end
        accept();
        n_cmp++;
        if (rxValid !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_accept: got valid %b want 0", rxValid);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_start: got busy %b want 1", busy);
        end
        repeat (100) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rise_cnt !== 0 || rxValid !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_reject: got busy %b frames %0d valid %b want 0 0 0",
                     busy, rise_cnt, rxValid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        partial = 8'h81;
        send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, 64);
        @(posedge clk);
        #1;
        send_bit(1'b0, 64);
        for (int i = 0; i < 3; i++) send_bit(partial[i], 64);
        rx = partial[3];
        repeat (32) @(posedge clk);
        #1;
        rx = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rxValid, parityError, framingError, overrunError, busy} !== 5'b0 ||
            rxData !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid: got flags %b data %h want 00000 00",
                     {rxValid, parityError, framingError, overrunError, busy}, rxData);
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clear_mon();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 64);
        n_cmp++;
        if (rxData !== 8'h81 || rise_cnt !== 1 || framingError !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_recover: got data %h frames %0d ferr %b want 81 1 0",
                     rxData, rise_cnt, framingError);
        end
        accept();
    endtask

    task automatic test_os13();
        set_cfg(16'd3, 5'd13, 4'd5, 1'b1, 1'b0, 2'd1);
        clear_mon();
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1, 1'b1, 39);
        n_cmp++;
        if (rxData !== 8'h1F || parityError !== 1'b0 || framingError !== 1'b0) begin
            n_bad++;
            $display("FAIL os13_word: got data %h perr %b ferr %b want 1f 0 0",
                     rxData, parityError, framingError);
        end
        n_cmp++;
        if (rise_cnt !== 1 || rise_cyc - start_cyc !== 294) begin
            n_bad++;
            $display("FAIL os13_latency: got frames %0d latency %0d want 1 294",
                     rise_cnt, rise_cyc - start_cyc);
        end
        accept();
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rxReady = 1'b0;
        set_cfg(16'd4, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1);
        test_reset();
        test_basic();
        test_parity();
        test_framing_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_os13();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
